// File: rtl/output_capture_buffer.sv
// Captures one accelerator job's result stream into a show-ahead FIFO and drains it over valid/ready.
// Define OUTPUT_CAPTURE_CHECKSUM_EN to add an XOR checksum of every captured word.
module output_capture_buffer #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              start,
   input  logic              running,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  word_count,
   output logic              overflow,
   output logic              done,
`ifdef OUTPUT_CAPTURE_CHECKSUM_EN
   output logic [DATA_W-1:0] checksum,
`endif
   output logic              busy
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic [AW:0]       r_wrPtr;
   logic [AW:0]       r_rdPtr;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic              r_runPrev;
   logic [CNT_W-1:0]  r_wordCount;
   logic              r_overflow;

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_pushReq;
   logic w_push;
   logic w_drop;
   logic w_runFall;
   logic w_accept;

   assign w_empty   = (r_wrPtr == r_rdPtr);
   assign w_full    = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
   assign w_pop     = !w_empty && out_ready;
   assign w_pushReq = (r_state == CAPTURE) && in_valid;
   // A full FIFO still takes a word when the head leaves in the same cycle.
   assign w_push    = w_pushReq && (!w_full || w_pop);
   assign w_drop    = w_pushReq && w_full && !w_pop;
   assign w_runFall = r_runPrev && !running;
   assign w_accept  = (r_state == IDLE) && start;

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (start) w_nextState = CAPTURE;
         CAPTURE: if (w_runFall) w_nextState = DRAIN;
         DRAIN:   if (w_empty && !w_push) w_nextState = DONE;
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_wrPtr     <= '0;
         r_rdPtr     <= '0;
         r_runPrev   <= 1'b0;
         r_wordCount <= '0;
         r_overflow  <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_runPrev <= running;
         if (w_push) r_wrPtr <= r_wrPtr + (AW+1)'(1);
         if (w_pop)  r_rdPtr <= r_rdPtr + (AW+1)'(1);
         if (w_accept) begin
            r_wordCount <= '0;
            r_overflow  <= 1'b0;
         end else begin
            if (w_push && (r_wordCount != '1)) r_wordCount <= r_wordCount + CNT_W'(1);
            if (w_drop) r_overflow <= 1'b1;
         end
      end
   end

   // Storage needs no reset: the pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wrPtr[AW-1:0]] <= in_data;
   end

`ifdef OUTPUT_CAPTURE_CHECKSUM_EN
   logic [DATA_W-1:0] r_checksum;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_checksum <= '0;
      end else if (w_accept) begin
         r_checksum <= '0;
      end else if (w_push) begin
         r_checksum <= r_checksum ^ in_data;
      end
   end

   assign checksum = r_checksum;
`endif

   assign out_valid  = !w_empty;
   assign out_data   = w_empty ? '0 : r_mem[r_rdPtr[AW-1:0]];
   assign word_count = r_wordCount;
   assign overflow   = r_overflow;
   assign done       = (r_state == DONE);
   assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_output_capture_buffer.sv
// Scoreboard bench for output_capture_buffer: a queue-based job model predicts every drained word and status flag.
// A second instance with a 3-bit counter shares the stimulus to exercise counter saturation.
module tb_output_capture_buffer;

   localparam int DATA_W    = 64;
   localparam int DEPTH     = 16;
   localparam int CNT_W     = 16;
   localparam int CNT_SMALL = 3;
   localparam int S_IDLE    = 0;
   localparam int S_CAPTURE = 1;
   localparam int S_DRAIN   = 2;
   localparam int S_DONE    = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [DATA_W-1:0] inData = '0;
   logic              inValid = 1'b0;
   logic              start = 1'b0;
   logic              running = 1'b0;
   logic              outReady = 1'b0;

   logic [DATA_W-1:0] outData;
   logic              outValid;
   logic [CNT_W-1:0]  wordCount;
   logic              overflow;
   logic              done;
   logic              busy;

   logic [DATA_W-1:0]  sOutData;
   logic               sOutValid;
   logic [CNT_SMALL-1:0] sWordCount;
   logic               sOverflow;
   logic               sDone;
   logic               sBusy;

`ifdef OUTPUT_CAPTURE_CHECKSUM_EN
   logic [DATA_W-1:0] checksum;
   logic [DATA_W-1:0] sChecksum;
`endif

   always #5 clk = ~clk;

   output_capture_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid), .start(start), .running(running),
      .out_data(outData), .out_valid(outValid), .out_ready(outReady), .word_count(wordCount),
      .overflow(overflow), .done(done),
`ifdef OUTPUT_CAPTURE_CHECKSUM_EN
      .checksum(checksum),
`endif
      .busy(busy)
   );

   output_capture_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_SMALL)) dutSmall (
      .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid), .start(start), .running(running),
      .out_data(sOutData), .out_valid(sOutValid), .out_ready(outReady), .word_count(sWordCount),
      .overflow(sOverflow), .done(sDone),
`ifdef OUTPUT_CAPTURE_CHECKSUM_EN
      .checksum(sChecksum),
`endif
      .busy(sBusy)
   );

   int checkCount = 0;
   int passCount  = 0;
   int doneSeen   = 0;
   bit monOn      = 1'b0;

   // Committed model of the job as seen after the most recent clock edge.
   logic [DATA_W-1:0] sbq[$];
   int                mdlState = S_IDLE;
   int unsigned       mdlCount = 0;
   int unsigned       mdlCountSmall = 0;
   bit                mdlOverflow = 1'b0;
   bit                mdlRunPrev = 1'b0;
   logic [DATA_W-1:0] mdlChecksum = '0;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   // Drive one cycle of inputs, predict the effect of the coming edge, then commit it after the edge.
   task automatic applyStimulus(input logic iv, input logic [63:0] d, input logic st,
                                input logic run, input logic rdy, input logic rs);
      bit pop, full, push, drop, accept;
      int nState;
      int unsigned nCount, nCountSmall;
      bit nOverflow;
      logic [DATA_W-1:0] nChecksum;
      inValid  = iv;
      inData   = d;
      start    = st;
      running  = run;
      outReady = rdy;
      rst      = rs;
      pop    = (sbq.size() != 0) && rdy;
      full   = (sbq.size() == DEPTH);
      push   = (mdlState == S_CAPTURE) && iv && (!full || pop);
      drop   = (mdlState == S_CAPTURE) && iv && full && !pop;
      accept = (mdlState == S_IDLE) && st;
      nState = mdlState;
      case (mdlState)
         S_IDLE:    if (st) nState = S_CAPTURE;
         S_CAPTURE: if (mdlRunPrev && !run) nState = S_DRAIN;
         S_DRAIN:   if (sbq.size() == 0 && !push) nState = S_DONE;
         default:   nState = S_IDLE;
      endcase
      nCount      = accept ? 0 : (push && mdlCount < (2**CNT_W - 1)) ? mdlCount + 1 : mdlCount;
      nCountSmall = accept ? 0 : (push && mdlCountSmall < (2**CNT_SMALL - 1)) ? mdlCountSmall + 1 : mdlCountSmall;
      nOverflow   = accept ? 1'b0 : (mdlOverflow || drop);
      nChecksum   = accept ? '0 : push ? (mdlChecksum ^ d) : mdlChecksum;
      @(posedge clk);
      #1;
      if (rs) begin
         sbq.delete();
         mdlState      = S_IDLE;
         mdlCount      = 0;
         mdlCountSmall = 0;
         mdlOverflow   = 1'b0;
         mdlRunPrev    = 1'b0;
         mdlChecksum   = '0;
      end else begin
         if (push) sbq.push_back(d);
         mdlState      = nState;
         mdlCount      = nCount;
         mdlCountSmall = nCountSmall;
         mdlOverflow   = nOverflow;
         mdlRunPrev    = run;
         mdlChecksum   = nChecksum;
      end
   endtask

   function automatic logic [63:0] randWord();
      return {$urandom(), $urandom()};
   endfunction

   // Monitor: inputs settle after each rising edge, so the falling edge shows exactly what the next edge will see.
   initial begin
      logic [DATA_W-1:0] exp;
      forever begin
         @(negedge clk);
         if (monOn) begin
            checkOutput("out_valid", outValid, sbq.size() != 0);
            checkOutput("small_out_valid", sOutValid, sbq.size() != 0);
            if (outValid && outReady) begin
               if (sbq.size() == 0) begin
                  checkOutput("pop_unexpected", outValid, 1'b0);
               end else begin
                  exp = sbq.pop_front();
                  checkOutput("out_data", outData, exp);
                  checkOutput("small_out_data", sOutData, exp);
               end
            end
            checkOutput("word_count", wordCount, 64'(mdlCount));
            checkOutput("small_word_count", sWordCount, 64'(mdlCountSmall));
            checkOutput("overflow", overflow, mdlOverflow);
            checkOutput("done", done, mdlState == S_DONE);
            checkOutput("busy", busy, mdlState != S_IDLE);
`ifdef OUTPUT_CAPTURE_CHECKSUM_EN
            checkOutput("checksum", checksum, mdlChecksum);
`endif
            if (done) doneSeen++;
         end
      end
   end

   task automatic idleCycles(input int n, input logic rdy);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, rdy, 1'b0);
   endtask

   initial begin
      int doneBefore;
      int len;
      $display("[TB] output_capture_buffer scoreboard bench");
      @(posedge clk);
      #1;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      monOn = 1'b1;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("reset_out_valid", outValid, 1'b0);
      checkOutput("reset_out_data", outData, '0);
      checkOutput("reset_busy", busy, 1'b0);

      // Basic job with the writer always ready.
      doneBefore = doneSeen;
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 64'(i), 1'b0, 1'b1, 1'b1, 1'b0);
      idleCycles(5, 1'b1);
      checkOutput("basic_count", wordCount, 64'd5);
      checkOutput("basic_overflow", overflow, 1'b0);
      checkOutput("basic_done_pulses", 64'(doneSeen - doneBefore), 64'd1);
`ifdef OUTPUT_CAPTURE_CHECKSUM_EN
      checkOutput("basic_checksum", checksum, 64'h1);
`endif

      // Full FIFO takes a word when a pop happens in the same cycle.
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, randWord(), 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, randWord(), 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("full_pushpop_overflow", overflow, 1'b0);
      checkOutput("full_pushpop_count", wordCount, 64'(DEPTH + 1));
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      idleCycles(DEPTH + 4, 1'b1);

      // Backpressure: the word after DEPTH is dropped.
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i <= DEPTH; i++) applyStimulus(1'b1, randWord(), 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("bp_overflow", overflow, 1'b1);
      checkOutput("bp_count", wordCount, 64'(DEPTH));
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      idleCycles(DEPTH + 4, 1'b1);

      // Stray valid in IDLE and a second start during capture are ignored.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, randWord(), 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("stray_idle_count", wordCount, 64'(DEPTH));
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, randWord(), 1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) applyStimulus(1'b1, randWord(), 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("stray_start_count", wordCount, 64'd5);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      idleCycles(4, 1'b1);

      // Reset with three words buffered.
      doneBefore = doneSeen;
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, randWord(), 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("rst_mid_out_valid", outValid, 1'b0);
      checkOutput("rst_mid_count", wordCount, 64'd0);
      checkOutput("rst_mid_busy", busy, 1'b0);
      idleCycles(4, 1'b1);
      checkOutput("rst_mid_no_done", 64'(doneSeen - doneBefore), 64'd0);

      // Saturation of the narrow counter while draining.
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, randWord(), 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("sat_small_count", sWordCount, 64'd7);
      checkOutput("sat_wide_count", wordCount, 64'd10);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      idleCycles(4, 1'b1);

      // Randomized jobs: random valid, ready, stray starts and ignored words while draining.
      for (int job = 0; job < 8; job++) begin
         applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
         len = $urandom_range(5, 40);
         for (int c = 0; c < len; c++)
            applyStimulus(1'($urandom_range(0, 3) != 0), randWord(), 1'($urandom_range(0, 15) == 0),
                          1'b1, 1'($urandom_range(0, 1)), 1'b0);
         for (int k = 0; k < 80 && !(mdlState == S_IDLE && sbq.size() == 0); k++)
            applyStimulus(1'($urandom_range(0, 1)), randWord(), 1'b0, 1'b0,
                          1'($urandom_range(0, 3) != 0), 1'b0);
         checkOutput("rand_job_idle", busy, 1'b0);
      end

      idleCycles(2, 1'b1);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/output_capture_buffer.md
# output_capture_buffer

Sink for the accelerator's result stream, which carries no backpressure: every word presented with `in_valid` high must be taken in that cycle. The block captures words into an internal FIFO and drains them to a memory-write port through a valid/ready handshake. It tracks the accelerator's `start`/`running` pair to frame one job, counts the captured words, flags any drop, and pulses `done` once the job's data has fully drained. It sits between the accelerator output and the memory-side writer, in the same slot the testbench occupies today.

## Interface
- `DATA_W`, default 64: word width; equals the accelerator memory bus width.
- `DEPTH`, default 16: FIFO depth in words; must be a power of two and at least 2.
- `CNT_W`, default 16: width of the word counter.

- `clk`, input, 1: clock; all logic on the rising edge.
- `rst`, input, 1: reset; synchronous and active-high.
- `in_data`, input, DATA_W: result word from the accelerator.
- `in_valid`, input, 1: result word present this cycle; no ready exists.
- `start`, input, 1: job-start pulse, the same signal driven into the accelerator.
- `running`, input, 1: accelerator busy flag.
- `out_data`, output, DATA_W: FIFO head word.
- `out_valid`, output, 1: FIFO not empty.
- `out_ready`, input, 1: memory writer accepts `out_data`.
- `word_count`, output, CNT_W: words captured since the last accepted `start`.
- `overflow`, output, 1: sticky; at least one word dropped in this job.
- `done`, output, 1: one-cycle pulse when the job is fully drained.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, CAPTURE, DRAIN, DONE.
- IDLE:
  - `start`=1 → CAPTURE.
  - On that same edge, clear `word_count` and `overflow`.
  - FIFO contents are not cleared.
  - `in_valid` in IDLE is ignored: no push, no count.
- CAPTURE:
  - `in_valid`=1 with FIFO not full, or full with a pop in the same cycle → push `in_data` and increment `word_count`.
  - `in_valid`=1 with FIFO full and no pop → word dropped, `overflow` set, `word_count` unchanged.
- Leaving CAPTURE:
  - A falling edge of `running` (registered previous value 1, current value 0) → DRAIN.
  - `in_valid` in the cycle of the falling edge is still captured.
  - A job in which `running` never rises stays in CAPTURE until the next reset.
- DRAIN:
  - Further `in_valid` is ignored.
  - FIFO empty, with no push this cycle → DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` while not in IDLE is ignored.
- Pop: `out_valid && out_ready`. Pop is legal in every state, so leftover data drains from IDLE as well.
- FIFO:
  - Show-ahead: `out_data` is the head whenever `out_valid`=1; `out_data` is don't-care when empty.
  - Read and write pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH.
  - Full when the pointer MSBs differ and the remaining bits are equal.
- `word_count` saturates at 2^CNT_W−1 and does not wrap.
- `out_data` must hold stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset values:
  - State IDLE, pointers 0.
  - `out_valid`=0, `out_data`=0, `word_count`=0, `overflow`=0, `done`=0, `busy`=0.
- Reset mid-job: all of the above apply on the next edge, and FIFO contents are discarded.
- Capture latency: a word pushed at edge N into an empty FIFO gives `out_valid`=1 and that word on `out_data` after edge N.
- Throughput: one push and one pop per cycle, sustained.
- Full capacity: exactly DEPTH words are held without a drop.
- `done` timing: `done` rises on the edge after the edge at which the last word was popped with `running` already low.
- `busy` rises on the edge that accepts `start`.

## Configuration
- `OUTPUT_CAPTURE_CHECKSUM_EN` defined:
  - Adds output `checksum` [DATA_W], reset value 0.
  - Cleared together with `word_count` on an accepted `start`.
  - XOR-accumulates every pushed word.
  - Dropped words are excluded.
- `OUTPUT_CAPTURE_CHECKSUM_EN` undefined: the port and its logic are absent, and all other behaviour is identical.

## Test plan
- Basic job, `out_ready` tied to 1:
  - Stimulus: `start`, `running` high, 5 words 0x1–0x5 on consecutive cycles, then `running` falls.
  - Response: `out_data` delivers 0x1–0x5 in order, each one cycle after its push; `word_count`=5; `overflow`=0; one `done` pulse; checksum=0x1 (when enabled).
- Backpressure:
  - Stimulus: `out_ready`=0; push DEPTH=16 words; then a 17th word.
  - Response: no drop for the first 16; the 17th sets `overflow`=1; `word_count`=16. After `out_ready`=1, the first 16 words drain in order.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full, `in_valid`=1 and `out_ready`=1 in the same cycle.
  - Response: the word is accepted; `overflow` stays 0.
- Stray inputs:
  - Stimulus: `in_valid` in IDLE; `start` during CAPTURE.
  - Response: the word is ignored with `word_count` unchanged; the second `start` is ignored with the counters not cleared.
- Reset mid-job:
  - Stimulus: `rst` asserted with 3 words buffered.
  - Response: the next cycle shows `out_valid`=0, `word_count`=0, state IDLE, and no `done` pulse.
- Saturation, with CNT_W=3:
  - Stimulus: push 10 words while draining.
  - Response: `word_count` holds at 7.
